fir_decim_fifo: RTL and testbench

Output-side stage placed directly after the 17-tap FIR filter. It consumes the filter's 10-bit signed sample stream and decimates it by an integrate-and-dump average. Each averaged sample is rounded and saturated to 8 bits, then buffered in a small FIFO. The FIFO drives a ready/valid interface towards the sink, so the downstream consumer can stall without stalling the filter.

---
 rtl/fir_decim_fifo_if.sv | 12 +
 rtl/fir_decim_fifo.sv | 110 +++++++++++
 tb/tb_fir_decim_fifo.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fir_decim_fifo_if.sv
// Sample stream between the FIR output stage and its neighbours: filter-side
// samples in, decimated samples out towards the sink with ready/valid.
interface fir_decim_fifo_if;
    logic signed [9:0] data_i;
    logic              valid_i;
    logic signed [7:0] data_o;
    logic              valid_o;
    logic              ready_i;

    modport master (output data_i, valid_i, ready_i, input data_o, valid_o);
    modport slave  (input data_i, valid_i, ready_i, output data_o, valid_o);
endinterface

// File: rtl/fir_decim_fifo.sv
// Integrate-and-dump decimator with round/saturate to 8 bits, feeding a
// show-ahead FIFO so the sink can stall without stalling the filter.
module fir_decim_fifo #(
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fir_decim_fifo_if.slave        bus,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o
);
    localparam int SH   = $clog2(DECIM);
    localparam int AW   = $clog2(DEPTH);
    localparam int ACCW = 10 + SH;
    localparam int PW   = (SH > 0) ? SH : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);

    logic [PW-1:0]          phase_q, phase_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] din, sum, avg;
    logic signed [9:0]      avg10;
    logic signed [10:0]     avg_r, rnd;
    logic [7:0]             res;
    logic [7:0]             out_q, out_d;
    logic                   push_q, push_d;

    logic [AW:0]            wr_q, wr_d, rd_q, rd_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             mem_q [DEPTH];
    logic                   full, empty, pop, push;

    assign din = bus.data_i;

    // The sum includes the current sample so the group closes on its last input.
    always_comb begin
        sum   = (phase_q == '0) ? din : acc_q + din;
        avg   = sum >>> SH;
        avg10 = avg[9:0];
        avg_r = {avg10[9], avg10} + 11'sd2;
        rnd   = avg_r >>> 2;
        if (rnd > 11'sd127)       res = 8'h7F;
        else if (rnd < -11'sd128) res = 8'h80;
        else                      res = rnd[7:0];
    end

    always_comb begin
        phase_d = phase_q;
        acc_d   = acc_q;
        out_d   = out_q;
        push_d  = 1'b0;
        if (bus.valid_i) begin
            acc_d = sum;
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                push_d  = 1'b1;
                out_d   = res;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            push_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            push_q  <= push_d;
        end
    end

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && bus.ready_i;
    assign push  = push_q && (!full || pop);

    always_comb begin
        wr_d  = push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d  = pop  ? rd_q + (AW+1)'(1) : rd_q;
        ovf_d = ovf_q || (push_q && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_q[AW-1:0]] <= out_q;
    end

    assign bus.valid_o = !empty;
    assign bus.data_o  = empty ? 8'sd0 : mem_q[rd_q[AW-1:0]];
    assign level_o     = wr_q - rd_q;
    assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo at DECIM=4, DEPTH=4 with hand-computed results.
module tb_fir_decim_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] level;
    logic       ovf;
    int         n_chk = 0;
    int         n_pass = 0;

    fir_decim_fifo_if bus();

    fir_decim_fifo #(.DECIM(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .level_o(level), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        bus.data_i  = 10'(v);
        bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
    endtask

    task automatic group(input int v);
        repeat (4) send(v);
    endtask

    // Output appears two edges after the last sample, then is popped.
    task automatic expect_one(input string tag, input logic [7:0] e);
        chk({tag, "_lat"}, {31'b0, bus.valid_o}, 32'd0);
        step();
        chk({tag, "_vld"}, {31'b0, bus.valid_o}, 32'd1);
        chk({tag, "_dat"}, {24'b0, bus.data_o}, {24'b0, e});
        chk({tag, "_lvl"}, {29'b0, level}, 32'd1);
        bus.ready_i = 1'b1;
        step();
        bus.ready_i = 1'b0;
        chk({tag, "_pop"}, {29'b0, level}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_d"}, {24'b0, bus.data_o}, 32'd0);
        chk({tag, "_v"}, {31'b0, bus.valid_o}, 32'd0);
        chk({tag, "_l"}, {29'b0, level}, 32'd0);
        chk({tag, "_o"}, {31'b0, ovf}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;
        step();
        step();
        chk_zero("rst");
        rst = 1'b0;

        group(100);   expect_one("p100", 8'h19);
        group(-3);    expect_one("m3", 8'hFF);
        group(-2);    expect_one("m2", 8'h00);
        send(1); send(2); send(3); send(5);
        expect_one("mix", 8'h01);
        group(511);   expect_one("satp", 8'h7F);
        group(-512);  expect_one("satn", 8'h80);

        // Valid on even cycles only; 4th valid sample lands at i=6.
        for (int i = 0; i < 8; i++) begin
            bus.data_i  = 10'd40;
            bus.valid_i = (i % 2 == 0);
            step();
            if (i == 6) chk("gap_lat", {31'b0, bus.valid_o}, 32'd0);
        end
        bus.valid_i = 1'b0;
        chk("gap_vld", {31'b0, bus.valid_o}, 32'd1);
        chk("gap_dat", {24'b0, bus.data_o}, 32'h0A);
        bus.ready_i = 1'b1;
        step();
        bus.ready_i = 1'b0;
        chk("gap_pop", {29'b0, level}, 32'd0);

        // Reset with one result queued and a partial group in flight.
        group(40);
        step();
        chk("pre_rst_lvl", {29'b0, level}, 32'd1);
        send(40); send(40);
        rst = 1'b1;
        step();
        chk_zero("mid_rst");
        rst = 1'b0;
        group(40);
        expect_one("post_rst", 8'h0A);

        // Backpressure: five results into four entries.
        for (int g = 1; g <= 5; g++) group(4 * g);
        step();
        chk("bp_lvl", {29'b0, level}, 32'd4);
        chk("bp_ovf", {31'b0, ovf}, 32'd1);
        bus.ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("bp_pop%0d", k), {24'b0, bus.data_o}, 32'(k));
            step();
        end
        bus.ready_i = 1'b0;
        chk("bp_empty", {31'b0, bus.valid_o}, 32'd0);
        chk("bp_lvl0", {29'b0, level}, 32'd0);
        chk("bp_sticky", {31'b0, ovf}, 32'd1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ovf_clr", {31'b0, ovf}, 32'd0);

        // Full FIFO with a pop on the push cycle: push accepted.
        for (int g = 1; g <= 5; g++) group(4 * g);
        chk("fp_full", {29'b0, level}, 32'd4);
        bus.ready_i = 1'b1;
        step();
        bus.ready_i = 1'b0;
        chk("fp_lvl", {29'b0, level}, 32'd4);
        chk("fp_ovf", {31'b0, ovf}, 32'd0);
        bus.ready_i = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("fp_pop%0d", k), {24'b0, bus.data_o}, 32'(k));
            step();
        end
        bus.ready_i = 1'b0;
        chk("fp_empty", {29'b0, level}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
